intc_gen: RTL and testbench
===========================

# intc_gen

Parametrised interrupt controller for the system's done-signal fabric. It collects N_SRC completion pulses or levels into sticky pending bits and gates them with a per-source enable register. It arbitrates among the enabled pending sources, raises `irq`, and presents the winning source's vector address on `EAddr` until the CPU returns `iack`. Sits between the accelerator/peripheral `done` outputs and the CPU interrupt input.

## Interface
Parameters:
- `N_SRC`, 4, number of interrupt sources (2..32)
- `ADDR_W`, 32, width of `EAddr`
- `VEC_BASE`, 32'h0000_0100, vector address of source 0
- `VEC_STRIDE`, 32'h0000_0010, address step between consecutive sources

Ports:
- `clk`  in  1  single system clock, all logic rising-edge
- `rst`  in  1  synchronous, active-low reset
- `done`  in  N_SRC  per-source event; bit i high in a cycle sets pending i
- `en_wr`  in  1  write strobe for the enable register
- `en_din`  in  N_SRC  new enable mask, 1 = source enabled
- `iack`  in  1  CPU acknowledge of the current interrupt
- `irq`  out  1  interrupt request to the CPU
- `EAddr`  out  ADDR_W  vector address of the granted source
- `src_id`  out  $clog2(N_SRC)  index of the granted source
- `pend`  out  N_SRC  raw pending bits, for status readback

## Operation
- Reset values while `rst`=0 at a clock edge:
  - `pend`=0, enable register = all ones, `irq`=0, `EAddr`=0, `src_id`=0
  - FSM returns to IDLE; round-robin pointer = N_SRC-1
- Pending: bit i sets on any edge where `done[i]`=1 and holds until cleared by acknowledge of source i.
  - Set and clear of the same bit in the same cycle: set wins, so no event is lost.
  - A source holding `done` high re-pends immediately after its ack.
- Enable: `en_wr`=1 loads `en_din` at the edge.
  - A disabled source still accumulates pending but is not arbitrated.
  - Disabling the currently granted source does not revoke the grant.
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE when `pend & enable` is nonzero. The winner is latched into `src_id`, `EAddr` is loaded, and `irq`=1.
  - ACTIVE holds `src_id`, `EAddr` and `irq` stable until `iack`=1.
  - ACTIVE with `iack`=1 -> IDLE at that edge; pending[`src_id`] is cleared and `irq`=0.
  - `iack` in IDLE is ignored.
- Vector arithmetic: `EAddr` = `VEC_BASE` + `src_id`*`VEC_STRIDE`, computed at ADDR_W bits and truncated (wraps mod 2^ADDR_W).
- Default arbitration is fixed priority, with index 0 highest.

## Timing
- `done[i]` high at edge t -> `pend[i]`=1 after edge t.
- IDLE at edge t+1 with that bit enabled -> `irq`=1 and `EAddr` valid after edge t+1. Latency from `done` to `irq` is 2 cycles.
- `iack` sampled at edge k -> `irq`=0 after edge k.
- Earliest next `irq` is after edge k+1. This guarantees at least one low cycle between interrupts.
- `EAddr` and `src_id` keep their last value while in IDLE.
- Reset asserted mid-ACTIVE drops `irq` and clears all pending at that edge. No acknowledge is required.

## Configuration
- `INTC_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at (last granted index + 1) mod N_SRC.
  - The pointer updates on each IDLE->ACTIVE transition.
- `INTC_ROUND_ROBIN_EN` not defined: fixed priority, lowest index wins. No pointer register is built.

## Structure
- Package `intc_pkg`:
  - FSM state enum (`INTC_IDLE`, `INTC_ACTIVE`)
  - default `VEC_BASE`/`VEC_STRIDE` constants
  - a function computing `$clog2`-safe id width
- Sub-module `intc_arb`: combinational arbiter taking the request vector (and the pointer when round-robin is compiled in). It returns a grant index and a valid flag.
- Top `intc_gen` holds the pending/enable registers, FSM and vector computation.

## Test plan
- Reset, then `done`=4'b0100 for one cycle -> `irq`=1 two cycles later, `src_id`=2, `EAddr`=32'h120. `iack` pulse -> `irq`=0 next cycle and `pend`=0.
- `done`=4'b1010 same cycle, fixed priority -> first grant `src_id`=1 (`EAddr`=32'h110). After `iack` and one idle cycle -> `src_id`=3 (`EAddr`=32'h130).
- `en_din`=4'b1110 with `done[0]`=1 -> `pend[0]`=1 and `irq` stays 0. Writing `en_din`=4'b1111 -> `irq`=1 with `src_id`=0 two cycles later.
- With `INTC_ROUND_ROBIN_EN`, hold `done`=4'b1111 -> successive grants are 0,1,2,3,0, each ack followed by one low cycle on `irq`.
- `done[1]` asserted on the same edge `iack` acknowledges source 1 -> `pend[1]` remains 1 and a new `irq` for `src_id`=1 follows.
- Reset (`rst`=0) while `irq`=1 with `pend`=4'b0110 -> after the edge `irq`=0, `pend`=0, `EAddr`=0, and no grant follows without new `done`.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types and defaults for the intc_gen interrupt controller.
package intc_pkg;

    typedef enum logic [0:0] {
        INTC_IDLE   = 1'b0,
        INTC_ACTIVE = 1'b1
    } intc_state_e;

    localparam logic [31:0] INTC_DEF_VEC_BASE   = 32'h0000_0100;
    localparam logic [31:0] INTC_DEF_VEC_STRIDE = 32'h0000_0010;

    // Index width that never collapses to zero bits for tiny source counts.
    function automatic int intc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/intc_arb.sv
// Combinational arbiter: fixed priority (index 0 highest) by default,
// round-robin starting after the pointer when INTC_ROUND_ROBIN_EN is defined.
module intc_arb
    import intc_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = intc_id_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
`ifdef INTC_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]  ptr,
`endif
    output logic [ID_W-1:0]  gnt_idx,
    output logic             gnt_valid
);

`ifdef INTC_ROUND_ROBIN_EN
    logic [ID_W:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k + 1);
            if (cand >= (ID_W+1)'(N_SRC)) begin
                cand = cand - (ID_W+1)'(N_SRC);
            end
            if (req[cand[ID_W-1:0]]) begin
                gnt_idx   = cand[ID_W-1:0];
                gnt_valid = 1'b1;
            end
        end
    end
`else
    // Descending scan: the last hit is the lowest set index.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt_idx   = ID_W'(k);
                gnt_valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/intc_gen.sv
// Interrupt controller: sticky pending bits, enable mask, IDLE/ACTIVE FSM, vector address.
// Optional round-robin arbitration via INTC_ROUND_ROBIN_EN.
module intc_gen
    import intc_pkg::*;
#(
    parameter int                N_SRC      = 4,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(INTC_DEF_VEC_BASE),
    parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(INTC_DEF_VEC_STRIDE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC-1:0]              done,
    input  logic                          en_wr,
    input  logic [N_SRC-1:0]              en_din,
    input  logic                          iack,
    output logic                          irq,
    output logic [ADDR_W-1:0]             EAddr,
    output logic [intc_id_w(N_SRC)-1:0]   src_id,
    output logic [N_SRC-1:0]              pend
);

    localparam int ID_W = intc_id_w(N_SRC);

    intc_state_e       state_reg;
    logic [N_SRC-1:0]  pend_reg;
    logic [N_SRC-1:0]  pend_next;
    logic [N_SRC-1:0]  en_reg;
    logic [N_SRC-1:0]  clr_vec;
    logic              irq_reg;
    logic [ADDR_W-1:0] eaddr_reg;
    logic [ID_W-1:0]   src_id_reg;
    logic [ID_W-1:0]   gnt_idx;
    logic              gnt_valid;
    logic              ack_fire;
    logic [ADDR_W-1:0] vec_addr;

    assign ack_fire = (state_reg == INTC_ACTIVE) && iack;

    // Set beats clear so an event arriving with its own acknowledge is kept.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_pend
            assign clr_vec[gi]   = ack_fire && (src_id_reg == ID_W'(gi));
            assign pend_next[gi] = done[gi] | (pend_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    assign vec_addr = VEC_BASE + ADDR_W'(gnt_idx) * VEC_STRIDE;

`ifdef INTC_ROUND_ROBIN_EN
    logic [ID_W-1:0] ptr_reg;

    intc_arb #(.N_SRC(N_SRC), .ID_W(ID_W)) u_arb (
        .req       (pend_reg & en_reg),
        .ptr       (ptr_reg),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg <= ID_W'(N_SRC - 1);
        end else if (state_reg == INTC_IDLE && gnt_valid) begin
            ptr_reg <= gnt_idx;
        end
    end
`else
    intc_arb #(.N_SRC(N_SRC), .ID_W(ID_W)) u_arb (
        .req       (pend_reg & en_reg),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= INTC_IDLE;
            pend_reg   <= '0;
            en_reg     <= '1;
            irq_reg    <= 1'b0;
            eaddr_reg  <= '0;
            src_id_reg <= '0;
        end else begin
            pend_reg <= pend_next;
            if (en_wr) begin
                en_reg <= en_din;
            end
            case (state_reg)
                INTC_IDLE: begin
                    if (gnt_valid) begin
                        state_reg  <= INTC_ACTIVE;
                        irq_reg    <= 1'b1;
                        src_id_reg <= gnt_idx;
                        eaddr_reg  <= vec_addr;
                    end
                end
                INTC_ACTIVE: begin
                    // Grant is held even if its enable is removed meanwhile.
                    if (iack) begin
                        state_reg <= INTC_IDLE;
                        irq_reg   <= 1'b0;
                    end
                end
                default: state_reg <= INTC_IDLE;
            endcase
        end
    end

    assign irq    = irq_reg;
    assign EAddr  = eaddr_reg;
    assign src_id = src_id_reg;
    assign pend   = pend_reg;

endmodule

// File: tb/tb_intc_gen.sv
// Self-checking bench for intc_gen: directed scenarios plus random traffic
// against a cycle-level behavioural model of the controller.
module tb_intc_gen;

    localparam int          N      = 4;
    localparam logic [31:0] BASE   = 32'h0000_0100;
    localparam logic [31:0] STRIDE = 32'h0000_0010;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] done;
    logic         en_wr;
    logic [N-1:0] en_din;
    logic         iack;
    logic         irq;
    logic [31:0]  EAddr;
    logic [1:0]   src_id;
    logic [N-1:0] pend;

    int n_checks = 0;
    int n_err    = 0;
    int cyc_no   = 0;

    // Behavioural model state
    bit          m_pend [N];
    bit          m_en   [N];
    bit          m_active;
    int          m_src;
    logic [31:0] m_addr;
    int          m_ptr;

    always #5 clk = ~clk;

    intc_gen dut (
        .clk    (clk),
        .rst    (rst),
        .done   (done),
        .en_wr  (en_wr),
        .en_din (en_din),
        .iack   (iack),
        .irq    (irq),
        .EAddr  (EAddr),
        .src_id (src_id),
        .pend   (pend)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns -1 when no enabled source is pending.
    function automatic int pick_winner();
        int w = -1;
`ifdef INTC_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int i = (m_ptr + k) % N;
            if (w < 0 && m_pend[i] && m_en[i]) w = i;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (w < 0 && m_pend[i] && m_en[i]) w = i;
        end
`endif
        return w;
    endfunction

    function automatic logic [N-1:0] model_pend_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_en[i]   = 1'b1;
        end
        m_active = 1'b0;
        m_src    = 0;
        m_addr   = 32'h0;
        m_ptr    = N - 1;
    endtask

    task automatic model_edge();
        bit new_pend [N];
        int w;
        if (!rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            new_pend[i] = m_pend[i];
            if (m_active && iack && m_src == i) new_pend[i] = 1'b0;
            if (done[i]) new_pend[i] = 1'b1;
        end
        if (!m_active) begin
            w = pick_winner();
            if (w >= 0) begin
                m_active = 1'b1;
                m_src    = w;
                m_addr   = BASE + 32'(w) * STRIDE;
                m_ptr    = w;
            end
        end else if (iack) begin
            m_active = 1'b0;
        end
        if (en_wr) begin
            for (int i = 0; i < N; i++) m_en[i] = en_din[i];
        end
        for (int i = 0; i < N; i++) m_pend[i] = new_pend[i];
    endtask

    // One clock: drive inputs, advance model at the edge, compare all outputs.
    task automatic cyc(input logic [N-1:0] d, input logic ew, input logic [N-1:0] ed,
                       input logic ia, input logic r);
        @(negedge clk);
        done   = d;
        en_wr  = ew;
        en_din = ed;
        iack   = ia;
        rst    = r;
        @(posedge clk);
        model_edge();
        #1;
        cyc_no++;
        $display("cyc %0d rst=%b done=%b en_wr=%b en_din=%b iack=%b -> irq=%b src_id=%0d EAddr=%h pend=%b",
                 cyc_no, r, d, ew, ed, ia, irq, src_id, EAddr, pend);
        check("irq",    32'(irq),    32'(m_active));
        check("src_id", 32'(src_id), 32'(m_src));
        check("EAddr",  EAddr,       m_addr);
        check("pend",   32'(pend),   32'(model_pend_vec()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        done = '0; en_wr = 1'b0; en_din = '0; iack = 1'b0; rst = 1'b0;
        model_reset();

        // Reset state
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        check("rst_eaddr", EAddr, 32'd0);

        // Single source 2: two-cycle latency
        cyc(4'b0100, 1'b0, '0, 1'b0, 1'b1);
        check("t1_irq_early", 32'(irq), 32'd0);
        idle(1);
        check("t1_irq", 32'(irq), 32'd1);
        check("t1_src", 32'(src_id), 32'd2);
        check("t1_addr", EAddr, 32'h120);
        cyc('0, 1'b0, '0, 1'b1, 1'b1);
        check("t1_ack_irq", 32'(irq), 32'd0);
        check("t1_ack_pend", 32'(pend), 32'd0);
        check("t1_hold_addr", EAddr, 32'h120);

        // Two simultaneous sources
        cyc(4'b1010, 1'b0, '0, 1'b0, 1'b1);
        idle(1);
`ifndef INTC_ROUND_ROBIN_EN
        check("t2_first_src", 32'(src_id), 32'd1);
        check("t2_first_addr", EAddr, 32'h110);
`endif
        cyc('0, 1'b0, '0, 1'b1, 1'b1);
        check("t2_gap", 32'(irq), 32'd0);
        idle(1);
`ifndef INTC_ROUND_ROBIN_EN
        check("t2_second_src", 32'(src_id), 32'd3);
        check("t2_second_addr", EAddr, 32'h130);
`endif
        cyc('0, 1'b0, '0, 1'b1, 1'b1);
        cyc('0, 1'b0, '0, 1'b1, 1'b1);   // iack in IDLE is ignored

        // Disabled source accumulates but is not arbitrated
        cyc(4'b0001, 1'b1, 4'b1110, 1'b0, 1'b1);
        idle(2);
        check("t3_pend0", 32'(pend[0]), 32'd1);
        check("t3_no_irq", 32'(irq), 32'd0);
        cyc('0, 1'b1, 4'b1111, 1'b0, 1'b1);
        idle(1);
        check("t3_irq", 32'(irq), 32'd1);
        check("t3_src", 32'(src_id), 32'd0);
        cyc('0, 1'b0, '0, 1'b1, 1'b1);

        // done[1] on the same edge that acknowledges source 1
        cyc(4'b0010, 1'b0, '0, 1'b0, 1'b1);
        idle(1);
        check("t5_src", 32'(src_id), 32'd1);
        cyc(4'b0010, 1'b0, '0, 1'b1, 1'b1);
        check("t5_pend_kept", 32'(pend[1]), 32'd1);
        check("t5_gap", 32'(irq), 32'd0);
        idle(1);
        check("t5_regrant_irq", 32'(irq), 32'd1);
        check("t5_regrant_src", 32'(src_id), 32'd1);
        cyc('0, 1'b0, '0, 1'b1, 1'b1);
        idle(1);

        // Reset mid-ACTIVE
        cyc(4'b0110, 1'b0, '0, 1'b0, 1'b1);
        idle(1);
        check("t6_active", 32'(irq), 32'd1);
        cyc('0, 1'b0, '0, 1'b0, 1'b0);
        check("t6_irq", 32'(irq), 32'd0);
        check("t6_pend", 32'(pend), 32'd0);
        check("t6_addr", EAddr, 32'd0);
        idle(3);
        check("t6_no_grant", 32'(irq), 32'd0);

`ifdef INTC_ROUND_ROBIN_EN
        // Round-robin rotation with all sources held
        begin
            int exp_seq [5] = '{0, 1, 2, 3, 0};
            cyc(4'b1111, 1'b0, '0, 1'b0, 1'b1);
            for (int g = 0; g < 5; g++) begin
                cyc(4'b1111, 1'b0, '0, 1'b0, 1'b1);
                check("rr_irq", 32'(irq), 32'd1);
                check("rr_src", 32'(src_id), 32'(exp_seq[g]));
                cyc(4'b1111, 1'b0, '0, 1'b1, 1'b1);
                check("rr_gap", 32'(irq), 32'd0);
            end
            idle(1);
            cyc('0, 1'b0, '0, 1'b0, 1'b0);
        end
`endif

        // Random traffic against the model
        for (int t = 0; t < 400; t++) begin
            logic [N-1:0] d;
            logic [N-1:0] ed;
            logic         ew, ia, r;
            d  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            ew = ($urandom_range(0, 9) == 0);
            ed = N'($urandom);
            ia = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 79) != 0);
            cyc(d, ew, ed, ia, r);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
